// File: rtl/ifetch_pkg.sv
// ifetch_pkg: fetch-stage state encoding, ecall opcode and service codes
package ifetch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, HALT = 2'd2} state_t;
  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
  localparam logic [31:0] SVC_READ_INT = 32'd5;
  localparam logic [31:0] SVC_EXIT = 32'd10;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-flop synchronizer with rising-edge pulse, sync active-low reset
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= !reset ? 3'b000 : {s[1:0], d};
  assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC, ROM addressing, next-PC select and ecall wait/halt sequencing
// Optional retire counter output enabled by IFETCH_RETIRE_CNT_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  input  logic              branch_taken,
  input  logic              jal,
  input  logic              jalr,
  input  logic [31:0]       imm32,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       a7,
  input  logic              io_ack,
  output logic              io_wait,
  output logic              stall,
  output logic              ecall_done,
  output logic              halted
`ifdef IFETCH_RETIRE_CNT_EN
  , output logic [31:0]     retire_cnt
`endif
);
  state_t state, state_n;
  logic [31:0] pc_n;
  logic ack_pulse, is_ecall;
  edge_sync u_ack (.clk(clk), .reset(reset), .d(io_ack), .pulse(ack_pulse));
  assign instruction = imem_rdata;
  assign pc_plus4 = pc + 32'd4;
  assign is_ecall = imem_rdata == ECALL_INSTR;
  // ROM registers the address on the same edge pc updates, so instruction tracks pc
  assign imem_addr = reset ? pc_n[ADDR_W+1:2] : PC_RESET[ADDR_W+1:2];
  always_ff @(posedge clk) begin
    state <= !reset ? RUN : state_n;
    pc <= !reset ? PC_RESET : pc_n;
  end
  always_comb begin
    state_n = state;
    pc_n = pc_plus4;
    io_wait = 1'b0;
    stall = 1'b0;
    ecall_done = 1'b0;
    halted = 1'b0;
    case (state)
      RUN: begin
        if (jalr) pc_n = (rs1_data + imm32) & ~32'h1;
        else if (jal || branch_taken) pc_n = pc + imm32;
        else if (is_ecall && (a7 == SVC_READ_INT || a7 == SVC_EXIT)) begin
          pc_n = pc;
          state_n = a7 == SVC_EXIT ? HALT : WAIT;
        end
      end
      WAIT: begin
        io_wait = 1'b1;
        stall = 1'b1;
        ecall_done = ack_pulse;
        pc_n = ack_pulse ? pc_plus4 : pc;
        state_n = ack_pulse ? RUN : WAIT;
      end
      HALT: begin
        stall = 1'b1;
        halted = 1'b1;
        pc_n = pc;
      end
      default: state_n = RUN;
    endcase
  end
`ifdef IFETCH_RETIRE_CNT_EN
  always_ff @(posedge clk)
    retire_cnt <= !reset ? 32'd0 :
                  ((state == RUN && state_n == RUN) || ecall_done) ? retire_cnt + 32'd1 : retire_cnt;
`endif
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder/register file in the single-cycle RV32I core.
- Owns the PC, drives the synchronous instruction-ROM address, computes the next PC from branch, jal and jalr.
- Presents the fetched instruction to the decoder.
- Sequences ecall services: stalls for console input (a7=5) until the confirm button is pressed; halts on a7=10.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 14, instruction-ROM word-address width (ROM depth 2^ADDR_W words).

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  synchronous, active-low reset.
- imem_addr  output  ADDR_W  ROM word address = pc_next[ADDR_W+1:2]; ROM registers it on the clk edge.
- imem_rdata  input  32  ROM data, valid one edge after imem_addr.
- instruction  output  32  = imem_rdata; the instruction at pc.
- pc  output  32  current PC.
- pc_plus4  output  32  pc+4; link value for jal/jalr.
- branch_taken  input  1  conditional branch resolved taken (ALU compare result ANDed with branch flag).
- jal  input  1  current instruction is jal.
- jalr  input  1  current instruction is jalr.
- imm32  input  32  sign-extended immediate from the decoder.
- rs1_data  input  32  numRe1 from the register file.
- a7  input  32  register x17 from the register file.
- io_ack  input  1  raw confirm button, asynchronous to clk.
- io_wait  output  1  high while waiting for input; the board lights an LED.
- stall  output  1  high in WAIT or HALT; the core gates regWrite and memWrite with ~stall.
- ecall_done  output  1  one-cycle pulse in the cycle the input ecall completes; the core enables the a0 write.
- halted  output  1  high in HALT.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=RUN, pc=PC_RESET.
  - io_wait, stall, ecall_done and halted all 0.
  - Synchronizer flops cleared.
  - While reset is low, imem_addr=PC_RESET[ADDR_W+1:2], so the first instruction is valid on the first edge after release.
- Fetch latency: pc and the ROM output update on the same edge, so instruction always corresponds to pc (zero bubble).
- is_ecall = (instruction==32'h0000_0073).
- pc_next priority in RUN:
  1. jalr: (rs1_data+imm32) & ~32'h1.
  2. jal: pc+imm32.
  3. branch_taken: pc+imm32.
  4. is_ecall with a7==5 or a7==10: pc (hold).
  5. Otherwise: pc+4.
- Arithmetic: all 32-bit, wrap-around modulo 2^32, no overflow detection. Bits [1:0] of the target are not checked.
- State RUN:
  - is_ecall && a7==5: go to WAIT.
  - is_ecall && a7==10: go to HALT.
  - Any other ecall (e.g. a7=1 print): behaves as a normal instruction, pc+4; no stall.
- State WAIT:
  - pc held; stall=1, io_wait=1.
  - On a synchronized rising edge of io_ack: ecall_done=1 for that cycle, pc_next=pc+4, go to RUN.
  - A button already held on entry does not complete the wait; a new rising edge is required.
- State HALT:
  - pc held, stall=1, halted=1.
  - Only reset exits HALT.
- io_ack conditioning: 2-flop synchronizer, then a rising-edge detect. Minimum response is 3 clk edges after the press; a held button produces one ecall_done.
- Simultaneous events:
  - Reset dominates all.
  - jal/jalr/branch_taken are ignored outside RUN.
  - If the decoder asserts jal/jalr together with is_ecall, jalr > jal > branch > ecall.
- Reset mid-WAIT or mid-HALT: returns to RUN at PC_RESET; a pending ack is discarded.

Optional Feature:
- Macro: IFETCH_RETIRE_CNT_EN.
- Defined:
  - Extra output retire_cnt (32 bits), reset to 0.
  - Increments on every clk edge where state==RUN and the instruction is not entering WAIT or HALT.
  - Also increments on the ecall_done cycle.
  - Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ifetch_pkg:
  - state encoding (RUN=2'd0, WAIT=2'd1, HALT=2'd2).
  - ECALL_INSTR=32'h0000_0073.
  - Service codes SVC_READ_INT=5, SVC_EXIT=10.
- Sub-module: edge_sync (2-flop synchronizer plus rising-edge pulse, synchronous active-low reset), instantiated for io_ack.

Test Plan:
- Reset release: PC_RESET=0, ROM[0]=32'h00500093 -> pc=0 and instruction=32'h00500093 on the first edge; pc=4 on the next edge.
- Branch, then jalr:
  - At pc=8 with branch_taken=1, imm32=-8 -> pc=0 next edge.
  - Then jalr=1, rs1_data=32'h105, imm32=4 -> pc=32'h108.
- Input ecall:
  - At pc=0x20, instruction 0x00000073, a7=5 -> stall=1, io_wait=1, pc stays 0x20.
  - Hold io_ack high from entry: no completion.
  - Release, then press: ecall_done pulses once about 3 edges later; pc=0x24; stall=0.
- Exit ecall: a7=10 at pc=0x40 -> halted=1 and pc=0x40 for 100 cycles despite jal=1. Then reset low for 1 edge -> pc=0, state RUN.
- Print ecall and wrap-around:
  - a7=1 ecall -> pc advances by 4, no stall.
  - pc=32'hFFFF_FFFC -> pc+4 wraps to 0.
  - With IFETCH_RETIRE_CNT_EN defined, retire_cnt equals the count of non-stalled RUN cycles.
